// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer.
// Owns the fetch PC and drives the external PC source mux: it supplies PC+4 and the
// aligned redirect target, selects between them, and loads the mux output back into
// the PC whenever fetch can advance. EX-stage redirects that arrive while the PC is
// held are parked in a pending register. After a redirect is applied, the wrong-path
// slots are squashed for FLUSH_CYCLES cycles.

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] pc_source_i,
    output logic [31:0] pc_o,
    output logic [31:0] next_pc_o,
    output logic [31:0] branch_pc_o,
    output logic        pc_select_o,
    output logic        if_valid_o,
    output logic        flush_o,
    output logic        misaligned_o
);

    // Sequencer states
    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StPend  = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    // Squash window length loaded when a redirect is applied (legal range 1..3)
    localparam logic [1:0] FlushInit = FLUSH_CYCLES[1:0];

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        valid_q;

    logic        adv;
    logic        in_flush;
    logic        br_accept;
    logic [31:0] br_target_aligned;
    logic [31:0] redirect_src;
    logic        apply;

    // Redirect decode and mux control
    always_comb begin
        adv               = !stall_i && imem_ready_i;
        in_flush          = (state_q == StFlush);
        // A branch reported during the squash window comes from a squashed slot
        br_accept         = branch_taken_i && !in_flush;
        br_target_aligned = {branch_target_i[31:2], 2'b00};
        // A fresh branch beats a parked one (latest redirect wins)
        redirect_src      = br_accept ? br_target_aligned : pend_target_q;
        apply             = adv && (br_accept || pend_valid_q);
    end

    // Outputs toward the mux, imem and pipeline registers
    always_comb begin
        pc_o         = pc_q;
        next_pc_o    = pc_q + 32'd4;
        branch_pc_o  = redirect_src;
        pc_select_o  = apply;
        // The applying cycle already fetches from the wrong path, so flush it too
        flush_o      = in_flush || apply;
        if_valid_o   = valid_q && !in_flush;
        misaligned_o = br_accept && (branch_target_i[1:0] != 2'b00);
    end

    // Next-state logic for the PC, pending redirect and squash counter
    always_comb begin
        state_d       = state_q;
        pc_d          = adv ? pc_source_i : pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        flush_cnt_d   = flush_cnt_q;

        case (state_q)
            StRun: begin
                if (br_accept) begin
                    if (adv) begin
                        state_d     = StFlush;
                        flush_cnt_d = FlushInit;
                    end else begin
                        state_d       = StPend;
                        pend_valid_d  = 1'b1;
                        pend_target_d = br_target_aligned;
                    end
                end
            end
            StPend: begin
                if (adv) begin
                    // Mux picks redirect_src this cycle, so the parked target is consumed
                    state_d      = StFlush;
                    pend_valid_d = 1'b0;
                    flush_cnt_d  = FlushInit;
                end else if (br_accept) begin
                    pend_target_d = br_target_aligned;
                end
            end
            StFlush: begin
                // Counts cycles, not fetches: independent of adv
                if (flush_cnt_q <= 2'd1) begin
                    state_d     = StRun;
                    flush_cnt_d = 2'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d      = StRun;
                pend_valid_d = 1'b0;
                flush_cnt_d  = 2'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
            flush_cnt_q   <= 2'd0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            flush_cnt_q   <= flush_cnt_d;
            valid_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: the driver applies one cycle of stimulus,
// predicts that cycle's outputs from a behavioural model and queues them; a monitor
// pops and compares at the falling edge. The PC source mux is modelled outside the DUT.

module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        imem_ready_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_source;
    logic [31:0] pc_o;
    logic [31:0] next_pc_o;
    logic [31:0] branch_pc_o;
    logic        pc_select_o;
    logic        if_valid_o;
    logic        flush_o;
    logic        misaligned_o;

    always #5 clk = ~clk;

    // External PC source mux
    assign pc_source = pc_select_o ? branch_pc_o : next_pc_o;

    pc_fetch_ctrl #(
        .RESET_PC     (RESET_PC),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .imem_ready_i    (imem_ready_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .pc_source_i     (pc_source),
        .pc_o            (pc_o),
        .next_pc_o       (next_pc_o),
        .branch_pc_o     (branch_pc_o),
        .pc_select_o     (pc_select_o),
        .if_valid_o      (if_valid_o),
        .flush_o         (flush_o),
        .misaligned_o    (misaligned_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] bpc;
        logic        bpc_chk;
        logic        sel;
        logic        vld;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: fetch address, parked redirect, remaining squash cycles
    logic [31:0] m_pc;
    logic        m_pend_has;
    logic [31:0] m_pend;
    int          m_flush_left;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus plus its predicted response
    task automatic cyc(input logic r, input logic s, input logic rd, input logic b,
                       input logic [31:0] t);
        exp_t   e;
        logic   adv, flushing, take, redir;
        logic [31:0] tgt;
        rst_n = r; stall_i = s; imem_ready_i = rd; branch_taken_i = b; branch_target_i = t;

        adv      = !s && rd;
        flushing = (m_flush_left > 0);
        take     = b && !flushing;
        redir    = take || m_pend_has;
        tgt      = take ? (t & 32'hFFFF_FFFC) : m_pend;

        e.pc      = m_pc;
        e.npc     = m_pc + 32'd4;
        e.bpc     = tgt;
        e.bpc_chk = redir;
        e.sel     = adv && redir;
        e.vld     = m_valid && !flushing;
        e.fl      = flushing || (adv && redir);
        e.mis     = take && (t[1:0] != 2'b00);
        exp_q.push_back(e);

        if (!r) begin
            m_pc = RESET_PC; m_pend_has = 1'b0; m_flush_left = 0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b1;
            if (flushing) begin
                m_flush_left--;
                if (adv) m_pc = m_pc + 32'd4;
            end else if (adv && redir) begin
                m_pc = tgt; m_pend_has = 1'b0; m_flush_left = FLUSH_CYCLES;
            end else if (take) begin
                m_pend = tgt; m_pend_has = 1'b1;
            end else if (adv) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    // Hand-derived PC checkpoints from the directed scenarios
    task automatic chk_pc(input string name, input logic [31:0] req);
        check(name, pc_o, req);
    endtask

    // Monitor: compare every cycle's outputs against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_o", pc_o, e.pc);
                check("next_pc_o", next_pc_o, e.npc);
                if (e.bpc_chk) check("branch_pc_o", branch_pc_o, e.bpc);
                check("pc_select_o", {31'd0, pc_select_o}, {31'd0, e.sel});
                check("if_valid_o", {31'd0, if_valid_o}, {31'd0, e.vld});
                check("flush_o", {31'd0, flush_o}, {31'd0, e.fl});
                check("misaligned_o", {31'd0, misaligned_o}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; imem_ready_i = 1'b1;
        branch_taken_i = 1'b0; branch_target_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        m_pc = RESET_PC; m_pend_has = 1'b0; m_pend = 32'h0; m_flush_left = 0; m_valid = 1'b0;

        // Sequential fetch 0,4,8 then taken branch at 8
        chk_pc("reset_pc", 32'h0);
        go(2);
        chk_pc("seq_pc8", 32'h8);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk_pc("branch_pc100", 32'h100);
        go(3);
        chk_pc("after_flush", 32'h10C);

        // Redirect under stall: latest target wins
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk_pc("stall_hold", 32'h10C);
        go(1);
        chk_pc("stall_redirect", 32'h80);
        go(2);

        // Imem back-pressure parks the redirect
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_pc("imem_hold", 32'h88);
        go(1);
        chk_pc("imem_redirect", 32'h20);
        go(2);

        // Branch during the squash window is ignored
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk_pc("flush_ignore", 32'h208);
        go(1);

        // Misaligned target is aligned and flagged
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        chk_pc("misaligned_pc", 32'h100);
        go(2);

        // Reset while a redirect is parked drops it
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk_pc("reset_in_pend", RESET_PC);
        go(1);
        chk_pc("no_redirect_after_reset", 32'h4);

        // PC wrap
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk_pc("wrap_top", 32'hFFFF_FFFC);
        go(1);
        chk_pc("wrap_zero", 32'h0);
        go(2);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 5) == 0),
                $urandom());
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
